imem_fetch_resp: RTL

- Instruction-memory responder: the memory end of the program-counter address stream.
- Accepts word addresses from the PC/fetch side on a valid/ready request channel and returns 32-bit instruction words on a valid/ready response channel.
- Has a 2-entry response buffer for back-pressure and a program-load write port for testbench or boot.
- Sits between the program counter and the decode stage.

---
 rtl/imem_fetch_resp.sv | 79 +++++++
 1 files changed

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: takes word addresses from the fetch side and
// returns instruction words through a 2-entry response buffer, with a program-load port.
module imem_fetch_resp #(
  parameter int alen = 6,
  parameter int ilen = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req,
  input  logic [alen-1:0] addr,
  output logic            req_ready,
  output logic [ilen-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            flush,
  input  logic            ld_en,
  input  logic [alen-1:0] ld_addr,
  input  logic [ilen-1:0] ld_data
);

  localparam int depth = 2 ** alen;

  logic [ilen-1:0] mem  [depth];
  logic [ilen-1:0] slot [2];
  logic            head;
  logic            tail;
  logic [1:0]      count;
  logic            accept;
  logic            pop;

  // A pop frees a slot at the same edge, so a full buffer can still accept when draining.
  always_comb begin
    instr_valid = (count != 2'd0);
    pop         = instr_valid && instr_ready;
    req_ready   = reset && !ld_en && !flush && ((count != 2'd2) || pop);
    accept      = req && req_ready;
    instr       = instr_valid ? slot[head] : '0;
  end

  // NOTE: memory arrays carry no reset; contents survive reset and only the load port changes them.
  always_ff @(posedge clock) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Buffer slots hold data only; their validity is tracked by count, so they need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      slot[tail] <= mem[addr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (accept) begin
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
